// File: rtl/fifo_rd_stage_pkg.sv
// Shared types and helpers for the FIFO read-side drain stage.
package fifo_rd_stage_pkg;

  localparam int unsigned OUT_DEPTH = 3;

  typedef logic [1:0] ptr_t;
  typedef logic [1:0] cnt_t;

  // Pointers index a 3-entry buffer, so they wrap 2 -> 0 rather than at the power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(OUT_DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_stage_buf.sv
// 3-entry output buffer for the read drain stage: capture on push, transfer on valid && ready.
module fifo_rd_stage_buf
  import fifo_rd_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic [1:0]            cnt
);

  logic [DATA_WIDTH-1:0] mem_q [OUT_DEPTH];
  ptr_t                  head_q, tail_q;
  cnt_t                  cnt_q, cnt_d;
  logic                  pop;

  assign valid = (cnt_q != cnt_t'(0));
  assign data  = mem_q[head_q];
  assign cnt   = cnt_q;
  assign pop   = valid && ready;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= push_data;
        tail_q        <= ptr_inc(tail_q);
      end
      if (pop) begin
        head_q <= ptr_inc(head_q);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_rd_stage.sv
// Read-side drain stage: pops the async FIFO, absorbs its read latency, streams via valid/ready.
// Optional transfer counter port word_cnt_o is enabled with FIFO_RD_STAGE_CNT_EN.
module fifo_rd_stage
  import fifo_rd_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rd_en_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  empty_i,
  input  logic                  underflow_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  err_o
`ifdef FIFO_RD_STAGE_CNT_EN
  ,
  output logic [15:0]           word_cnt_o
`endif
);

  logic [1:0] cnt;
  logic       infl_q;
  logic       err_q;

  // Reserve a slot for the word in flight so a full buffer never receives a capture;
  // m_ready_i is deliberately not part of this term.
  assign rd_en_o = !rst && !empty_i && ((3'(cnt) + 3'(infl_q)) < 3'(OUT_DEPTH));
  assign err_o   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      infl_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      infl_q <= rd_en_o && !empty_i;
      if (underflow_i) begin
        err_q <= 1'b1;
      end
    end
  end

  fifo_rd_stage_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (infl_q),
    .push_data (rdata_i),
    .ready     (m_ready_i),
    .data      (m_data_o),
    .valid     (m_valid_o),
    .cnt       (cnt)
  );

`ifdef FIFO_RD_STAGE_CNT_EN
  logic [15:0] word_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= '0;
    end else if (m_valid_o && m_ready_i) begin
      word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  assign word_cnt_o = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stage.sv
// Scoreboard bench for fifo_rd_stage: FIFO model with registered read, expected-word queue.
module tb_fifo_rd_stage;

  localparam int DW = 8;
  localparam int MEM_SIZE = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en_o;
  logic [DW-1:0] rdata_i = '0;
  logic          empty_i;
  logic          underflow_i;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic          err_o;
`ifdef FIFO_RD_STAGE_CNT_EN
  logic [15:0]   word_cnt_o;
`endif

  always #5 clk = ~clk;

  fifo_rd_stage #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en_o     (rd_en_o),
    .rdata_i     (rdata_i),
    .empty_i     (empty_i),
    .underflow_i (underflow_i),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .err_o       (err_o)
`ifdef FIFO_RD_STAGE_CNT_EN
    ,
    .word_cnt_o  (word_cnt_o)
`endif
  );

  // FIFO model: stimulus owns wr_ptr, the model owns rd_ptr.
  logic [DW-1:0] mem [MEM_SIZE];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            pop_cnt = 0;
  logic          uf_model = 1'b0;
  logic          uf_force = 1'b0;

  assign empty_i     = (wr_ptr == rd_ptr);
  assign underflow_i = uf_model | uf_force;

  always @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= wr_ptr;
      uf_model <= 1'b0;
    end else begin
      uf_model <= rd_en_o && empty_i;
      if (rd_en_o && !empty_i) begin
        rdata_i <= mem[rd_ptr % MEM_SIZE];
        rd_ptr  <= rd_ptr + 1;
        pop_cnt <= pop_cnt + 1;
      end
    end
  end

  // Scoreboard
  logic [DW-1:0] exp_q [$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            xfer_cnt = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [DW-1:0] w);
    mem[wr_ptr % MEM_SIZE] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: compare each transfer against the queue; check stability during stalls.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", m_valid_o, 1);
        check("stall_data", m_data_o, data_prev);
      end
      if (m_valid_o && m_ready_i) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no transfer at %0t", m_data_o, $time);
        end else begin
          check("word_order", m_data_o, exp_q.pop_front());
        end
      end
      stall_prev = m_valid_o && !m_ready_i;
      data_prev  = m_data_o;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    int p0;
    rst       = 1'b1;
    m_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    load(8'hAA);
    @(negedge clk);
    check("rst_rd_en", rd_en_o, 0);
    check("rst_valid", m_valid_o, 0);
    check("rst_data", m_data_o, 0);
    check("rst_err", err_o, 0);
    @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;

    // Burst with ready high: 2-cycle latency, then one word per cycle
    m_ready_i = 1'b1;
    x0 = xfer_cnt;
    for (int i = 0; i < 16; i++) load(DW'(i));
    @(negedge clk);
    check("lat_rd_en_c0", rd_en_o, 1);
    check("lat_valid_c0", m_valid_o, 0);
    @(negedge clk);
    check("lat_valid_c1", m_valid_o, 0);
    @(negedge clk);
    check("lat_valid_c2", m_valid_o, 1);
    check("lat_data_c2", m_data_o, 8'h00);
    repeat (16) @(negedge clk);
    check("burst_throughput", xfer_cnt - x0, 16);
    check("burst_done_valid", m_valid_o, 0);
    check("burst_err", err_o, 0);

    // Backpressure: exactly 3 pops, head word held
    @(posedge clk);
    #1;
    m_ready_i = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) load(DW'(8'h40 + i));
    repeat (10) @(negedge clk);
    check("bp_pops", pop_cnt - p0, 3);
    check("bp_rd_en", rd_en_o, 0);
    check("bp_valid", m_valid_o, 1);
    check("bp_data", m_data_o, 8'h40);
    @(posedge clk);
    #1;
    m_ready_i = 1'b1;
    wait_drain("bp_drain", 100);
    check("bp_total_pops", pop_cnt - p0, 8);

    // Random ready over 200 words
    for (int i = 0; i < 200; i++) load(DW'($urandom_range(0, 255)));
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
      m_ready_i = 1'($urandom_range(0, 1));
    end
    m_ready_i = 1'b1;
    wait_drain("rand_drain", 20);
    check("rand_err", err_o, 0);

    // Reset mid-burst
    for (int i = 0; i < 16; i++) load(DW'(8'h80 + i));
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", m_valid_o, 0);
    check("mid_rst_err", err_o, 0);
    check("mid_rst_rd_en", rd_en_o, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) load(DW'(8'h90 + i));
    wait_drain("post_rst_drain", 100);

    // Sticky error flag
    @(posedge clk);
    #1;
    uf_force = 1'b1;
    @(negedge clk);
    check("err_before", err_o, 0);
    @(posedge clk);
    #1;
    uf_force = 1'b0;
    @(negedge clk);
    check("err_set", err_o, 1);
    repeat (5) @(negedge clk);
    check("err_sticky", err_o, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("err_cleared", err_o, 0);

`ifdef FIFO_RD_STAGE_CNT_EN
    check("cnt_after_rst", word_cnt_o, 0);
    begin
      int total;
      total = 0;
      for (int c = 0; c < 90000 && total < 65537; c++) begin
        @(posedge clk);
        #1;
        if (wr_ptr - rd_ptr < 2000) begin
          for (int k = 0; k < 1000 && total < 65537; k++) begin
            load(DW'(total));
            total++;
          end
        end
      end
      check("cnt_loaded", total, 65537);
    end
    wait_drain("cnt_drain", 5000);
    @(negedge clk);
    check("cnt_wrap", word_cnt_o, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
